// File: rtl/maze_pkg.sv
// Shared types and helpers for the maze solver: grid geometry, direction and solver state encodings.
package maze_pkg;

  localparam int GRID  = 16;
  localparam int CELLS = GRID * GRID;

  typedef enum logic [1:0] {DIR_UP, DIR_RIGHT, DIR_DOWN, DIR_LEFT} dir_e;

  typedef enum logic [1:0] {IDLE, RUN, SOLVED, FAIL} state_e;

  function automatic logic [7:0] cell_idx(input logic [3:0] x, input logic [3:0] y);
    return 8'(x) + 8'(GRID) * 8'(y);
  endfunction

endpackage

// File: rtl/maze_solver_stack.sv
// 256-entry LIFO of 8-bit cell indices with a registered top; holds the backtrack trail of the solver.
module maze_solver_stack (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [7:0] din_i,
  output logic [7:0] top_o,
  output logic       empty_o
);

  logic [7:0] mem_q [256];
  logic [8:0] ptr_q;
  logic [7:0] top_q;
  logic [7:0] rd_idx;

  // Entry below the current top becomes the new top after a pop.
  assign rd_idx = ptr_q[7:0] - 8'd2;

  always_ff @(posedge clk) begin
    if (push_i && !clr_i) mem_q[ptr_q[7:0]] <= din_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      top_q <= '0;
    end else if (clr_i) begin
      ptr_q <= '0;
      top_q <= '0;
    end else if (push_i) begin
      ptr_q <= ptr_q + 9'd1;
      top_q <= din_i;
    end else if (pop_i && ptr_q != 9'd0) begin
      ptr_q <= ptr_q - 9'd1;
      top_q <= (ptr_q >= 9'd2) ? mem_q[rd_idx] : 8'd0;
    end
  end

  assign top_o   = top_q;
  assign empty_o = (ptr_q == 9'd0);

endmodule

// File: rtl/maze_solver.sv
// Depth-first maze solver: snapshots the maze on start, takes one move per step period,
// and publishes the current path as a bitmap in the same layout as the maze.
module maze_solver #(
  parameter int STEP_W = 26,
  parameter int GRID   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [STEP_W-1:0] slow_time,
  input  logic [255:0]      maze_data,
  input  logic [4:0]        maze_width,
  input  logic [4:0]        maze_height,
  input  logic [3:0]        finish_x,
  input  logic [3:0]        finish_y,
  output logic [3:0]        curr_x,
  output logic [3:0]        curr_y,
  output logic [255:0]      path_data,
  output logic [8:0]        path_len,
  output logic              busy,
  output logic              solved,
  output logic              failed
);
  import maze_pkg::*;

  state_e            state_q, state_d;
  logic [STEP_W-1:0] cnt_q, cnt_d;
  logic              arm_q, arm_d;
  logic [3:0]        cx_q, cx_d, cy_q, cy_d;
  logic [8:0]        len_q, len_d;
  logic [CELLS-1:0]  vis_q, vis_d, path_q, path_d;

  logic [CELLS-1:0]  maze_q;
  logic [4:0]        w_q, h_q;
  logic [3:0]        fx_q, fy_q;

  logic              st_push, st_pop, st_clr, st_empty;
  logic [7:0]        st_top;

  logic [7:0]        cur_idx, up_idx, rt_idx, dn_idx, lf_idx, mv_idx;
  logic [3:0]        elig;
  dir_e              dir;

  assign cur_idx = cell_idx(cx_q, cy_q);
  assign up_idx  = cell_idx(cx_q, cy_q - 4'd1);
  assign rt_idx  = cell_idx(cx_q + 4'd1, cy_q);
  assign dn_idx  = cell_idx(cx_q, cy_q + 4'd1);
  assign lf_idx  = cell_idx(cx_q - 4'd1, cy_q);

  // Bounds are checked before the index is trusted, so a wrapped index never matters.
  assign elig = {
    (cx_q != 4'd0)                      && maze_q[lf_idx] && !vis_q[lf_idx],
    (({1'b0, cy_q} + 5'd1) < h_q)       && maze_q[dn_idx] && !vis_q[dn_idx],
    (({1'b0, cx_q} + 5'd1) < w_q)       && maze_q[rt_idx] && !vis_q[rt_idx],
    (cy_q != 4'd0)                      && maze_q[up_idx] && !vis_q[up_idx]
  };

  always_comb begin
    dir    = DIR_LEFT;
    mv_idx = lf_idx;
    if      (elig[0]) dir = DIR_UP;
    else if (elig[1]) dir = DIR_RIGHT;
    else if (elig[2]) dir = DIR_DOWN;
    case (dir)
      DIR_UP:    mv_idx = up_idx;
      DIR_RIGHT: mv_idx = rt_idx;
      DIR_DOWN:  mv_idx = dn_idx;
      DIR_LEFT:  mv_idx = lf_idx;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    arm_d   = arm_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    len_d   = len_q;
    vis_d   = vis_q;
    path_d  = path_q;
    st_push = 1'b0;
    st_pop  = 1'b0;
    st_clr  = 1'b0;
    if (state_q == RUN) begin
      // arm_q spends the cycle right after start without counting.
      if (arm_q) begin
        arm_d = 1'b0;
      end else if (cnt_q != slow_time) begin
        cnt_d = cnt_q + STEP_W'(1);
      end else begin
        cnt_d = '0;
        if (!maze_q[0]) begin
          state_d = FAIL;
          path_d  = '0;
          len_d   = '0;
        end else if (cx_q == fx_q && cy_q == fy_q) begin
          state_d = SOLVED;
        end else if (|elig) begin
          st_push        = 1'b1;
          cx_d           = mv_idx[3:0];
          cy_d           = mv_idx[7:4];
          vis_d[mv_idx]  = 1'b1;
          path_d[mv_idx] = 1'b1;
          len_d          = len_q + 9'd1;
        end else if (st_empty) begin
          state_d = FAIL;
          path_d  = '0;
          len_d   = '0;
        end else begin
          st_pop          = 1'b1;
          path_d[cur_idx] = 1'b0;
          cx_d            = st_top[3:0];
          cy_d            = st_top[7:4];
          len_d           = len_q - 9'd1;
        end
      end
    end
    if (start) begin
      state_d = RUN;
      cnt_d   = '0;
      arm_d   = 1'b1;
      cx_d    = '0;
      cy_d    = '0;
      len_d   = 9'd1;
      vis_d   = CELLS'(1);
      path_d  = CELLS'(1);
      st_push = 1'b0;
      st_pop  = 1'b0;
      st_clr  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      arm_q   <= 1'b0;
      cx_q    <= '0;
      cy_q    <= '0;
      len_q   <= '0;
      vis_q   <= '0;
      path_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      arm_q   <= arm_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      len_q   <= len_d;
      vis_q   <= vis_d;
      path_q  <= path_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      maze_q <= '0;
      w_q    <= '0;
      h_q    <= '0;
      fx_q   <= '0;
      fy_q   <= '0;
    end else if (start) begin
      maze_q <= maze_data;
      w_q    <= (maze_width == 5'd0 || maze_width > 5'(GRID)) ? 5'(GRID) : maze_width;
      h_q    <= (maze_height == 5'd0 || maze_height > 5'(GRID)) ? 5'(GRID) : maze_height;
      fx_q   <= finish_x;
      fy_q   <= finish_y;
    end
  end

  maze_solver_stack u_stack (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (st_clr),
    .push_i  (st_push),
    .pop_i   (st_pop),
    .din_i   (cur_idx),
    .top_o   (st_top),
    .empty_o (st_empty)
  );

  assign curr_x    = cx_q;
  assign curr_y    = cy_q;
  assign path_data = path_q;
  assign path_len  = len_q;
  assign busy      = (state_q == RUN);
  assign solved    = (state_q == SOLVED);
  assign failed    = (state_q == FAIL);

endmodule
